keypad_debouncer_rpt: RTL and testbench

//   Parametrised keypad debouncer that sits between the keypad scanner and the display/command logic.

---
 rtl/keypad_debouncer_rpt.sv | 147 ++++++++++++++
 tb/tb_keypad_debouncer_rpt.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debouncer_rpt.sv
// Keypad debouncer: debounces press and release of a KEY_W-bit code and emits
// one-cycle press / release / auto-repeat pulses plus a held level and stable code.
module keypad_debouncer_rpt #(
  parameter int unsigned KEY_W          = 4,
  parameter int unsigned PRESS_CYCLES   = 50,
  parameter int unsigned RELEASE_CYCLES = 50,
  parameter int unsigned REPEAT_DELAY   = 0,
  parameter int unsigned REPEAT_PERIOD  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  output logic [KEY_W-1:0] db_code,
  output logic             db_held,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             repeat_pulse
);

  localparam int unsigned CNT_MAX = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned RPT_TOP = REPEAT_DELAY + REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_TOP) + 1;

  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_DLY      = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_END      = RPT_W'(RPT_TOP);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RPT_W-1:0]   rpt_q, rpt_d, rpt_inc;
  logic [KEY_W-1:0]   cand_q, cand_d;
  logic [KEY_W-1:0]   db_code_q, db_code_d;
  logic               held_q, held_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               repeat_q, repeat_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rpt_q     <= '0;
      cand_q    <= '0;
      db_code_q <= '0;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rpt_q     <= rpt_d;
      cand_q    <= cand_d;
      db_code_q <= db_code_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rpt_d     = rpt_q;
    cand_d    = cand_q;
    db_code_d = db_code_q;
    held_d    = held_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    rpt_inc   = rpt_q + RPT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          cand_d  = key_code;
          cnt_d   = '0;
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!key_valid) begin
          state_d = IDLE;
        end else if (key_code != cand_q) begin
          cand_d = key_code;
          cnt_d  = '0;
        end else if (cnt_q == PRESS_LAST) begin
          state_d   = HELD;
          db_code_d = cand_q;
          held_d    = 1'b1;
          press_d   = 1'b1;
          rpt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (key_valid && (key_code == db_code_q)) begin
          // After the first repeat, rpt runs DELAY..DELAY+PERIOD and reloads to DELAY,
          // so it stays bounded while pulses continue indefinitely.
          if (REPEAT_DELAY != 0) begin
            if (rpt_inc == RPT_END) begin
              rpt_d    = RPT_DLY;
              repeat_d = 1'b1;
            end else begin
              rpt_d    = rpt_inc;
              repeat_d = (rpt_inc == RPT_DLY);
            end
          end
        end else begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_valid && (key_code == db_code_q)) begin
          state_d = HELD;
        end else if (cnt_q == RELEASE_LAST) begin
          state_d   = IDLE;
          held_d    = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign db_code       = db_code_q;
  assign db_held       = held_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_keypad_debouncer_rpt.sv
// Bench for keypad_debouncer_rpt: segment table, hand-written reset/latency sequences,
// and random segments checked each cycle against a run-length reference model.
module tb_keypad_debouncer_rpt;

  localparam int P   = 50;
  localparam int R   = 50;
  localparam int D   = 100;
  localparam int PER = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] db_code;
  logic       db_held, press_pulse, release_pulse, repeat_pulse;

  keypad_debouncer_rpt #(
    .KEY_W(4),
    .PRESS_CYCLES(P),
    .RELEASE_CYCLES(R),
    .REPEAT_DELAY(D),
    .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_valid(key_valid),
    .key_code(key_code),
    .db_code(db_code),
    .db_held(db_held),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: run lengths of samples rather than FSM states.
  logic       m_held;
  logic [3:0] m_db;
  logic [3:0] run_code;
  int         idle_run, miss_run, hcount;
  logic       e_press, e_rel, e_rpt;

  int seg_p, seg_r, seg_rp;

  typedef struct {
    logic       v;
    logic [3:0] code;
    int         len;
    logic [3:0] e_db;
    logic       e_held;
    int         e_p;
    int         e_r;
    int         e_rp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0; m_db = '0; run_code = '0;
    idle_run = 0; miss_run = 0; hcount = 0;
    e_press = 1'b0; e_rel = 1'b0; e_rpt = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c);
    e_press = 1'b0; e_rel = 1'b0; e_rpt = 1'b0;
    if (!m_held) begin
      if (v) begin
        if (idle_run > 0 && c == run_code) idle_run++;
        else begin idle_run = 1; run_code = c; end
      end else begin
        idle_run = 0;
      end
      if (idle_run == P + 1) begin
        m_held = 1'b1; m_db = run_code; e_press = 1'b1;
        hcount = 0; miss_run = 0; idle_run = 0;
      end
    end else begin
      if (v && c == m_db) begin
        if (miss_run == 0) begin
          hcount++;
          if (D != 0 && hcount >= D && ((hcount - D) % PER) == 0) e_rpt = 1'b1;
        end
        miss_run = 0;
      end else begin
        miss_run++;
        if (miss_run == R + 1) begin
          m_held = 1'b0; e_rel = 1'b1; idle_run = 0;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [3:0] c);
    key_valid = v;
    key_code  = c;
    @(posedge clk);
    model_step(v, c);
    #1;
    chk("cycle", {db_code, db_held, press_pulse, release_pulse, repeat_pulse},
        {m_db, m_held, e_press, e_rel, e_rpt});
    seg_p  += int'(press_pulse);
    seg_r  += int'(release_pulse);
    seg_rp += int'(repeat_pulse);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("reset_clear", {db_code, db_held, press_pulse, release_pulse, repeat_pulse}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic add(input logic v, input logic [3:0] c, input int len, input logic [3:0] edb,
                     input logic eh, input int ep, input int er, input int erp);
    vec_t t;
    t.v = v; t.code = c; t.len = len; t.e_db = edb; t.e_held = eh;
    t.e_p = ep; t.e_r = er; t.e_rp = erp;
    tbl.push_back(t);
  endtask

  initial begin
    // Segment table: {valid, code, cycles} -> {db_code, db_held, press/release/repeat counts}
    add(1'b1, 4'h5, 60, 4'h5, 1'b1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      add(1'b1, 4'h5, 19, 4'h5, 1'b1, 0, 0, 0);
      add(1'b0, 4'h0, 1,  4'h5, 1'b1, 0, 0, 0);
    end
    add(1'b0, 4'h0, 60, 4'h5, 1'b0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      add(1'b1, 4'h5, 19, 4'h5, 1'b0, 0, 0, 0);
      add(1'b0, 4'h0, 1,  4'h5, 1'b0, 0, 0, 0);
    end
    add(1'b1, 4'h5, 60,  4'h5, 1'b1, 1, 0, 0);
    add(1'b1, 4'hA, 60,  4'h5, 1'b0, 0, 1, 0);
    add(1'b1, 4'hA, 60,  4'hA, 1'b1, 1, 0, 0);
    add(1'b0, 4'h0, 60,  4'hA, 1'b0, 0, 1, 0);
    add(1'b1, 4'h3, 250, 4'h3, 1'b1, 1, 0, 5);
    add(1'b0, 4'h0, 60,  4'h3, 1'b0, 0, 1, 0);

    reset = 1'b0; key_valid = 1'b0; key_code = '0;
    model_reset();
    #1;
    chk("reset_state", {db_code, db_held, press_pulse, release_pulse, repeat_pulse}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    foreach (tbl[i]) begin
      seg_p = 0; seg_r = 0; seg_rp = 0;
      for (int n = 0; n < tbl[i].len; n++) step(tbl[i].v, tbl[i].code);
      chk($sformatf("seg%0d_code", i), db_code, tbl[i].e_db);
      chk($sformatf("seg%0d_held", i), db_held, tbl[i].e_held);
      chk($sformatf("seg%0d_press", i), seg_p, tbl[i].e_p);
      chk($sformatf("seg%0d_release", i), seg_r, tbl[i].e_r);
      chk($sformatf("seg%0d_repeat", i), seg_rp, tbl[i].e_rp);
    end

    // Reset in the middle of PRESS_WAIT, then exact press latency afterwards.
    for (int n = 0; n < 20; n++) step(1'b1, 4'h5);
    do_reset();
    for (int n = 1; n <= P + 1; n++) begin
      step(1'b1, 4'h6);
      chk("press_latency", press_pulse, (n == P + 1) ? 1 : 0);
    end
    chk("press_code", db_code, 4'h6);

    // Reset while HELD: no release pulse may follow.
    for (int n = 0; n < 10; n++) step(1'b1, 4'h6);
    do_reset();
    seg_p = 0; seg_r = 0; seg_rp = 0;
    for (int n = 0; n < 60; n++) step(1'b0, 4'h0);
    chk("no_release_after_reset", seg_r, 0);
    chk("code_cleared", db_code, 4'h0);
    for (int n = 1; n <= P + 1; n++) step(1'b1, 4'h9);
    chk("press_after_reset", {db_code, db_held}, {4'h9, 1'b1});

    // Exact release latency: first mismatching sample is n=1.
    for (int n = 1; n <= R + 1; n++) begin
      step(1'b0, 4'h0);
      chk("release_latency", release_pulse, (n == R + 1) ? 1 : 0);
    end

    // Random segments against the model.
    for (int s = 0; s < 40; s++) begin
      logic       v;
      logic [3:0] c;
      int         len;
      v   = ($urandom_range(0, 9) < 7);
      c   = 4'($urandom_range(0, 2) * 5);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(20, 160));
      for (int n = 0; n < len; n++) step(v, c);
    end
    for (int n = 0; n < 60; n++) step(1'b0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
